sram_axi_bridge: RTL and testbench
==================================

Name: sram_axi_bridge

Overview:
- Responder for the cache-side SRAM-like request interface (req/wr/size/addr/wdata → addr_ok/data_ok/rdata).
- Converts each accepted request into a single-beat AXI3 master transaction.
- One instance sits behind each cache channel (inst, data) in front of the AXI crossbar.
- Allows one outstanding transaction at a time; strictly in-order.

Parameters:
- AXI_ID, 4'd0, constant value driven on arid/awid/wid.
- ID_W, 4, AXI ID width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- req  in  1  SRAM-like request valid
- wr  in  1  1 = write, 0 = read
- size  in  2  0 = byte, 1 = half, 2 = word
- addr  in  32  byte address
- wdata  in  32  write data, lane-aligned to addr[1:0]
- rdata  out  32  read data, valid when data_ok
- addr_ok  out  1  request accepted this cycle
- data_ok  out  1  transaction complete this cycle
- arid/arvalid/araddr/arsize/arlen/arburst  out  ID_W/1/32/3/4/2  AXI read address channel
- arready  in  1
- rid/rdata_axi/rresp/rlast/rvalid  in  ID_W/32/2/1/1
- rready  out  1
- awid/awvalid/awaddr/awsize/awlen/awburst  out  ID_W/1/32/3/4/2
- awready  in  1
- wid/wvalid/wdata_axi/wstrb/wlast  out  ID_W/1/32/4/1
- wready  in  1
- bid/bresp/bvalid  in  ID_W/2/1
- bready  out  1

Behaviour:
- Reset (asynchronous, active-high), all outputs 0: addr_ok, data_ok, all valids, rready, bready, rdata. State = IDLE.
- States: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP.
- IDLE:
  - addr_ok = req, combinational.
  - On req, latch wr/size/addr/wdata.
  - Go to RD_ADDR if wr = 0, else WR_REQ.
- RD_ADDR: arvalid = 1. On arvalid & arready → RD_DATA.
- RD_DATA: rready = 1. On rvalid:
  - register rdata ← rdata_axi;
  - assert data_ok for exactly one cycle, the cycle after the handshake;
  - → IDLE.
- WR_REQ:
  - awvalid and wvalid are both raised on entry.
  - Each valid drops independently after its own handshake; aw_done/w_done flags record completion.
  - Same-cycle AW and W handshakes are legal.
  - When both are done → WR_RESP.
- WR_RESP: bready = 1. On bvalid → data_ok pulse next cycle, → IDLE.
- addr_ok is 0 in every state except IDLE.
- A new request is accepted no earlier than the cycle data_ok is high, i.e. IDLE is re-entered that cycle.
- Fixed AXI fields: arlen = awlen = 0, arburst = awburst = INCR (2'b01), wlast = 1.
- arsize and awsize = {1'b0, size}.
- araddr and awaddr = latched addr, unaligned low bits preserved.
- wstrb derived from size and addr[1:0]:
  - byte: 4'b0001 << addr[1:0];
  - half: addr[1] ? 4'b1100 : 4'b0011;
  - word: 4'b1111;
  - size = 3 is illegal: wstrb = 0.
- rresp and bresp are ignored; an error response still completes with data_ok.
- rid and bid are ignored (single outstanding).
- Valids are held until their handshake, and AXI address/data is held stable while valid is high.
- Reset mid-transaction aborts to IDLE immediately; no data_ok is generated.

Decomposition:
- Shared package axi_defs_pkg holds:
  - constants BURST_INCR, SIZE_BYTE/HALF/WORD;
  - state encoding for the bridge FSM;
  - the wstrb decode function.
- One natural sub-module: axi_wstrb_gen (size, addr[1:0] → wstrb), reusable by the uncached path.

Test Plan:
- Read word 0x1FC0_0004, arready after 2 cycles, rvalid with 0xDEADBEEF after 3 → addr_ok in cycle 0; araddr = 0x1FC0_0004, arsize = 2; data_ok one cycle with rdata = 0xDEADBEEF; addr_ok low throughout.
- Byte write to addr 0x...03, wdata 0xAB000000, awready and wready same cycle → wstrb = 4'b1000, awsize = 0; bvalid after 1 cycle → data_ok pulse; FSM returns to IDLE.
- Half write to addr 0x...02, wready 3 cycles before awready → wvalid drops after its handshake while awvalid stays high; wstrb = 4'b1100; exactly one data_ok.
- Back-to-back reads with req held high → second addr_ok coincides with first data_ok cycle; no overlapping arvalid.
- rst asserted while in RD_DATA → all valids and data_ok 0 in that cycle; a later rvalid is ignored; state is IDLE.
- bresp = 2'b10 (SLVERR) on a write → data_ok still pulses once; bridge accepts the next req.

Source files
------------

// File: rtl/axi_defs_pkg.sv
// Shared AXI constants, bridge FSM encoding and the write-strobe decode used by
// the SRAM-like to AXI3 bridges.
package axi_defs_pkg;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] SIZE_BYTE  = 2'd0;
  localparam logic [1:0] SIZE_HALF  = 2'd1;
  localparam logic [1:0] SIZE_WORD  = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_ADDR = 3'd1,
    ST_RD_DATA = 3'd2,
    ST_WR_REQ  = 3'd3,
    ST_WR_RESP = 3'd4
  } bridge_state_t;

  // Lane enables for a lane-aligned store; size 3 is illegal and writes nothing.
  function automatic logic [3:0] wstrb_decode(input logic [1:0] size, input logic [1:0] lo);
    logic [3:0] strb;
    case (size)
      SIZE_BYTE: strb = 4'b0001 << lo;
      SIZE_HALF: strb = lo[1] ? 4'b1100 : 4'b0011;
      SIZE_WORD: strb = 4'b1111;
      default:   strb = 4'b0000;
    endcase
    return strb;
  endfunction

endpackage

// File: rtl/sram_axi_bridge_if.sv
// AXI3 master-side channel bundle for one cache channel; the bridge takes the
// master view, the crossbar (or a bench slave model) the slave view.
interface sram_axi_bridge_if #(
  parameter int ID_W = 4
);
  logic [ID_W-1:0] arid;
  logic            arvalid;
  logic [31:0]     araddr;
  logic [2:0]      arsize;
  logic [3:0]      arlen;
  logic [1:0]      arburst;
  logic            arready;

  logic [ID_W-1:0] rid;
  logic [31:0]     rdata_axi;
  logic [1:0]      rresp;
  logic            rlast;
  logic            rvalid;
  logic            rready;

  logic [ID_W-1:0] awid;
  logic            awvalid;
  logic [31:0]     awaddr;
  logic [2:0]      awsize;
  logic [3:0]      awlen;
  logic [1:0]      awburst;
  logic            awready;

  logic [ID_W-1:0] wid;
  logic            wvalid;
  logic [31:0]     wdata_axi;
  logic [3:0]      wstrb;
  logic            wlast;
  logic            wready;

  logic [ID_W-1:0] bid;
  logic [1:0]      bresp;
  logic            bvalid;
  logic            bready;

  modport master (
    output arid, arvalid, araddr, arsize, arlen, arburst,
    input  arready,
    input  rid, rdata_axi, rresp, rlast, rvalid,
    output rready,
    output awid, awvalid, awaddr, awsize, awlen, awburst,
    input  awready,
    output wid, wvalid, wdata_axi, wstrb, wlast,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    input  arid, arvalid, araddr, arsize, arlen, arburst,
    output arready,
    output rid, rdata_axi, rresp, rlast, rvalid,
    input  rready,
    input  awid, awvalid, awaddr, awsize, awlen, awburst,
    output awready,
    input  wid, wvalid, wdata_axi, wstrb, wlast,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );

endinterface

// File: rtl/axi_wstrb_gen.sv
// Write-strobe generator: access size plus low address bits to AXI byte lanes.
// Shared with the uncached store path.
module axi_wstrb_gen
  import axi_defs_pkg::*;
(
  input  logic [1:0] size,
  input  logic [1:0] addr_lo,
  output logic [3:0] wstrb
);

  assign wstrb = wstrb_decode(size, addr_lo);

endmodule

// File: rtl/sram_axi_bridge.sv
// SRAM-like request responder that turns each accepted request into a single
// beat AXI3 read or write; one transaction in flight, strictly in order.
module sram_axi_bridge
  import axi_defs_pkg::*;
#(
  parameter int            ID_W   = 4,
  parameter logic [ID_W-1:0] AXI_ID = 4'd0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req,
  input  logic                 wr,
  input  logic [1:0]           size,
  input  logic [31:0]          addr,
  input  logic [31:0]          wdata,
  output logic [31:0]          rdata,
  output logic                 addr_ok,
  output logic                 data_ok,
  sram_axi_bridge_if.master    axi
);

  bridge_state_t state_r, state_nxt_s;
  logic [1:0]    size_r;
  logic [31:0]   addr_r;
  logic [31:0]   wdata_r;
  logic [31:0]   rdata_r;
  logic          aw_done_r;
  logic          w_done_r;
  logic          data_ok_r;
  logic          accept_s;
  logic          aw_hs_s;
  logic          w_hs_s;
  logic          done_s;
  logic          awvalid_s;
  logic          wvalid_s;
  logic [3:0]    wstrb_s;
  logic          unused_s;

  // Requests are only taken in IDLE; addr_ok is held low while reset is applied.
  assign accept_s  = (state_r == ST_IDLE) && req && !rst;
  assign awvalid_s = (state_r == ST_WR_REQ) && !aw_done_r;
  assign wvalid_s  = (state_r == ST_WR_REQ) && !w_done_r;
  assign aw_hs_s   = awvalid_s && axi.awready;
  assign w_hs_s    = wvalid_s && axi.wready;

  // Next-state decode; done_s marks the response handshake that ends a transaction.
  always_comb begin
    state_nxt_s = state_r;
    done_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (req) state_nxt_s = wr ? ST_WR_REQ : ST_RD_ADDR;
        else     state_nxt_s = ST_IDLE;
      end
      ST_RD_ADDR: begin
        if (axi.arready) state_nxt_s = ST_RD_DATA;
        else             state_nxt_s = ST_RD_ADDR;
      end
      ST_RD_DATA: begin
        if (axi.rvalid) begin
          state_nxt_s = ST_IDLE;
          done_s      = 1'b1;
        end else begin
          state_nxt_s = ST_RD_DATA;
        end
      end
      ST_WR_REQ: begin
        if ((aw_done_r || aw_hs_s) && (w_done_r || w_hs_s)) state_nxt_s = ST_WR_RESP;
        else                                                  state_nxt_s = ST_WR_REQ;
      end
      ST_WR_RESP: begin
        if (axi.bvalid) begin
          state_nxt_s = ST_IDLE;
          done_s      = 1'b1;
        end else begin
          state_nxt_s = ST_WR_RESP;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= ST_IDLE;
    else     state_r <= state_nxt_s;
  end

  // Request capture, per-channel write completion flags, read data and data_ok.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      size_r    <= 2'd0;
      addr_r    <= 32'd0;
      wdata_r   <= 32'd0;
      rdata_r   <= 32'd0;
      aw_done_r <= 1'b0;
      w_done_r  <= 1'b0;
      data_ok_r <= 1'b0;
    end else begin
      if (accept_s) begin
        size_r  <= size;
        addr_r  <= addr;
        wdata_r <= wdata;
      end
      // Flags live only inside WR_REQ so every write starts with both valids up.
      if (state_r != ST_WR_REQ) begin
        aw_done_r <= 1'b0;
        w_done_r  <= 1'b0;
      end else begin
        if (aw_hs_s) aw_done_r <= 1'b1;
        if (w_hs_s)  w_done_r  <= 1'b1;
      end
      if ((state_r == ST_RD_DATA) && axi.rvalid) rdata_r <= axi.rdata_axi;
      data_ok_r <= done_s;
    end
  end

  axi_wstrb_gen u_wstrb (
    .size    (size_r),
    .addr_lo (addr_r[1:0]),
    .wstrb   (wstrb_s)
  );

  assign addr_ok = accept_s;
  assign data_ok = data_ok_r;
  assign rdata   = rdata_r;

  assign axi.arid    = AXI_ID;
  assign axi.arvalid = (state_r == ST_RD_ADDR);
  assign axi.araddr  = addr_r;
  assign axi.arsize  = {1'b0, size_r};
  assign axi.arlen   = 4'd0;
  assign axi.arburst = BURST_INCR;
  assign axi.rready  = (state_r == ST_RD_DATA);

  assign axi.awid    = AXI_ID;
  assign axi.awvalid = awvalid_s;
  assign axi.awaddr  = addr_r;
  assign axi.awsize  = {1'b0, size_r};
  assign axi.awlen   = 4'd0;
  assign axi.awburst = BURST_INCR;

  assign axi.wid       = AXI_ID;
  assign axi.wvalid    = wvalid_s;
  assign axi.wdata_axi = wdata_r;
  assign axi.wstrb     = wstrb_s;
  assign axi.wlast     = 1'b1;
  assign axi.bready    = (state_r == ST_WR_RESP);

  // Response IDs and error codes carry no information for a single in-order requester.
  assign unused_s = ^{axi.rid, axi.rresp, axi.rlast, axi.bid, axi.bresp};

endmodule

// File: tb/tb_sram_axi_bridge.sv
// Randomized bench for sram_axi_bridge: SRAM-side driver, AXI slave with random
// latencies, a word-memory reference model and a data_ok scoreboard.
module tb_sram_axi_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        wr = 1'b0;
  logic [1:0]  size = 2'd0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] rdata;
  logic        addr_ok;
  logic        data_ok;

  always #5 clk = ~clk;

  sram_axi_bridge_if #(.ID_W(4)) bus ();

  sram_axi_bridge #(.ID_W(4), .AXI_ID(4'd0)) dut (
    .clk(clk), .rst(rst), .req(req), .wr(wr), .size(size), .addr(addr),
    .wdata(wdata), .rdata(rdata), .addr_ok(addr_ok), .data_ok(data_ok), .axi(bus)
  );

  int n_check = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_check++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
  endtask

  typedef struct { bit rd; logic [31:0] data; } sb_t;
  typedef struct { bit wr; logic [31:0] addr; logic [1:0] size; logic [31:0] wdata; logic [3:0] strb; } ax_t;
  sb_t sb_q[$];
  ax_t ax_q[$];

  logic [31:0] mdl  [logic [31:0]];
  logic [31:0] smem [logic [31:0]];

  function automatic logic [31:0] init_word(input logic [31:0] wa);
    return wa ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] mdl_rd(input logic [31:0] a);
    logic [31:0] wa = {a[31:2], 2'b00};
    return mdl.exists(wa) ? mdl[wa] : init_word(wa);
  endfunction

  function automatic logic [31:0] smem_rd(input logic [31:0] a);
    logic [31:0] wa = {a[31:2], 2'b00};
    return smem.exists(wa) ? smem[wa] : init_word(wa);
  endfunction

  // Byte lanes touched by an access, from the size/offset rules.
  function automatic logic [3:0] lanes(input logic [1:0] sz, input logic [1:0] lo);
    logic [3:0] s = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      case (sz)
        2'd0:    s[i] = (i == int'(lo));
        2'd1:    s[i] = ((i / 2) == (int'(lo) / 2));
        2'd2:    s[i] = 1'b1;
        default: s[i] = 1'b0;
      endcase
    end
    return s;
  endfunction

  // Slave behaviour knobs: forced latencies (-1 = random), error responses, read stall.
  int f_ar = -1, f_r = -1, f_aw = -1, f_w = -1, f_b = -1;
  bit force_err = 1'b0, hold_r = 1'b0, slave_off = 1'b0, inject_r = 1'b0;

  function automatic int dly(input int f);
    return (f >= 0) ? f : int'($urandom_range(0, 3));
  endfunction

  // Driver: present a request and wait for addr_ok, which must be high exactly when nothing is outstanding.
  task automatic issue(input logic w, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    int  n = 0;
    bit  got = 1'b0;
    logic [3:0] s;
    logic [31:0] word;
    req = 1'b1; wr = w; size = sz; addr = a; wdata = d;
    while (!got && n < 1000) begin
      #2;
      chk("addr_ok", {31'd0, addr_ok}, {31'd0, (sb_q.size() == 0)});
      if (addr_ok) begin
        got = 1'b1;
        s = lanes(sz, a[1:0]);
        if (!w) begin
          sb_q.push_back('{1'b1, mdl_rd(a)});
        end else begin
          word = mdl_rd(a);
          for (int i = 0; i < 4; i++) if (s[i]) word[8*i +: 8] = d[8*i +: 8];
          mdl[{a[31:2], 2'b00}] = word;
          sb_q.push_back('{1'b0, 32'd0});
        end
        ax_q.push_back('{w, a, sz, d, s});
      end
      @(negedge clk);
      n++;
    end
    if (!got) begin
      chk("accept_timeout", 32'd0, 32'd1);
      req = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (sb_q.size() != 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", {31'd0, (sb_q.size() == 0)}, 32'd1);
  endtask

  // Scoreboard monitor: every data_ok retires the oldest accepted request.
  always @(negedge clk) begin
    sb_t e;
    #1;
    if (!rst && data_ok) begin
      if (sb_q.size() == 0) begin
        chk("data_ok_unexpected", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        if (e.rd) chk("rdata", rdata, e.data);
      end
    end
  end

  // AXI slave model with random latencies and its own memory.
  bit ar_act, r_act, wr_act, aw_act, w_act, b_act;
  int ar_d, r_d, aw_d, w_d, b_d;
  logic [31:0] r_addr;
  ax_t cur_r, cur_w;

  initial begin
    logic [31:0] word;
    bus.arready = 1'b0; bus.rvalid = 1'b0; bus.rdata_axi = 32'd0; bus.rresp = 2'd0;
    bus.rid = 4'd0; bus.rlast = 1'b0; bus.awready = 1'b0; bus.wready = 1'b0;
    bus.bvalid = 1'b0; bus.bresp = 2'd0; bus.bid = 4'd0;
    forever begin
      @(negedge clk);
      if (slave_off || rst) begin
        ar_act = 1'b0; r_act = 1'b0; wr_act = 1'b0; aw_act = 1'b0; w_act = 1'b0; b_act = 1'b0;
        ax_q.delete();
        bus.arready = 1'b0; bus.awready = 1'b0; bus.wready = 1'b0; bus.bvalid = 1'b0;
        bus.rvalid = inject_r; bus.rdata_axi = 32'h0BAD_0BAD;
        continue;
      end
      if (!ar_act && !r_act && bus.arvalid) begin
        if (ax_q.size() == 0 || ax_q[0].wr) chk("ar_expected", 32'd0, 32'd1);
        else begin cur_r = ax_q.pop_front(); ar_act = 1'b1; ar_d = dly(f_ar); end
      end else if (ar_act) chk("arvalid_hold", {31'd0, bus.arvalid}, 32'd1);
      else if (bus.arvalid) chk("arvalid_overlap", 32'd1, 32'd0);
      bus.arready = ar_act && (ar_d == 0);
      if (ar_act && ar_d > 0) ar_d--;
      bus.rvalid = r_act && (r_d == 0) && !hold_r;
      bus.rdata_axi = smem_rd(r_addr);
      bus.rresp = force_err ? 2'b10 : 2'($urandom_range(0, 3));
      bus.rid = 4'($urandom);
      bus.rlast = 1'b1;
      if (r_act && r_d > 0) r_d--;

      if (!wr_act && (bus.awvalid || bus.wvalid)) begin
        chk("aw_w_raised", {30'd0, bus.awvalid, bus.wvalid}, 32'd3);
        if (ax_q.size() == 0 || !ax_q[0].wr) chk("aw_expected", 32'd0, 32'd1);
        else begin
          cur_w = ax_q.pop_front();
          wr_act = 1'b1; aw_act = 1'b1; w_act = 1'b1;
          aw_d = dly(f_aw); w_d = dly(f_w);
        end
      end else if (wr_act) begin
        chk("awvalid_state", {31'd0, bus.awvalid}, {31'd0, aw_act});
        chk("wvalid_state", {31'd0, bus.wvalid}, {31'd0, w_act});
      end
      bus.awready = aw_act && (aw_d == 0);
      if (aw_act && aw_d > 0) aw_d--;
      bus.wready = w_act && (w_d == 0);
      if (w_act && w_d > 0) w_d--;
      bus.bvalid = b_act && (b_d == 0);
      bus.bresp = force_err ? 2'b10 : 2'($urandom_range(0, 3));
      bus.bid = 4'($urandom);
      if (b_act && b_d > 0) b_d--;

      #1;
      if (bus.arvalid && bus.arready) begin
        chk("araddr", bus.araddr, cur_r.addr);
        chk("arsize", {29'd0, bus.arsize}, {29'd0, 1'b0, cur_r.size});
        chk("arlen", {28'd0, bus.arlen}, 32'd0);
        chk("arburst", {30'd0, bus.arburst}, 32'd1);
        chk("arid", {28'd0, bus.arid}, 32'd0);
        ar_act = 1'b0; r_act = 1'b1; r_d = dly(f_r); r_addr = bus.araddr;
      end
      if (bus.rvalid && bus.rready) r_act = 1'b0;
      if (bus.awvalid && bus.awready) begin
        chk("awaddr", bus.awaddr, cur_w.addr);
        chk("awsize", {29'd0, bus.awsize}, {29'd0, 1'b0, cur_w.size});
        chk("awlen", {28'd0, bus.awlen}, 32'd0);
        chk("awburst", {30'd0, bus.awburst}, 32'd1);
        chk("awid", {28'd0, bus.awid}, 32'd0);
        aw_act = 1'b0;
      end
      if (bus.wvalid && bus.wready) begin
        chk("wdata", bus.wdata_axi, cur_w.wdata);
        chk("wstrb", {28'd0, bus.wstrb}, {28'd0, cur_w.strb});
        chk("wlast", {31'd0, bus.wlast}, 32'd1);
        chk("wid", {28'd0, bus.wid}, 32'd0);
        word = smem_rd(cur_w.addr);
        for (int i = 0; i < 4; i++) if (bus.wstrb[i]) word[8*i +: 8] = bus.wdata_axi[8*i +: 8];
        smem[{cur_w.addr[31:2], 2'b00}] = word;
        w_act = 1'b0;
      end
      if (bus.bvalid && bus.bready) begin b_act = 1'b0; wr_act = 1'b0; end
      if (wr_act && !aw_act && !w_act && !b_act) begin b_act = 1'b1; b_d = dly(f_b); end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Main sequence: reset, directed scenarios, random traffic, mid-transaction reset.
  initial begin
    int cnt;
    int n;
    logic w_rand;
    repeat (2) @(negedge clk);
    req = 1'b1;
    #1;
    chk("rst_addr_ok", {31'd0, addr_ok}, 32'd0);
    chk("rst_data_ok", {31'd0, data_ok}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_valids", {27'd0, bus.arvalid, bus.rready, bus.awvalid, bus.wvalid, bus.bready}, 32'd0);
    @(negedge clk);
    req = 1'b0;
    rst = 1'b0;

    // Boot-vector word read with slow address and data phases.
    mdl[32'h1FC0_0004] = 32'hDEAD_BEEF;
    smem[32'h1FC0_0004] = 32'hDEAD_BEEF;
    f_ar = 2; f_r = 3;
    @(negedge clk);
    issue(1'b0, 2'd2, 32'h1FC0_0004, 32'd0);
    req = 1'b0;
    wait_idle();

    // Byte store to lane 3 with AW and W accepted together.
    f_ar = -1; f_r = -1; f_aw = 0; f_w = 0; f_b = 1;
    issue(1'b1, 2'd0, 32'h0000_1003, 32'hAB00_0000);
    req = 1'b0;
    wait_idle();

    // Half store to the upper half with W accepted well before AW.
    f_aw = 3; f_w = 0; f_b = 0;
    issue(1'b1, 2'd1, 32'h0000_1002, 32'h1234_0000);
    req = 1'b0;
    wait_idle();
    f_aw = -1; f_w = -1; f_b = -1;

    // Back-to-back reads with req held high.
    issue(1'b0, 2'd2, 32'h0000_1000, 32'd0);
    issue(1'b0, 2'd0, 32'h0000_1003, 32'd0);
    req = 1'b0;
    wait_idle();

    // Error responses still complete.
    force_err = 1'b1;
    issue(1'b1, 2'd2, 32'h0000_1008, 32'hCAFE_F00D);
    issue(1'b0, 2'd2, 32'h0000_1008, 32'd0);
    req = 1'b0;
    wait_idle();
    force_err = 1'b0;

    // Illegal size 3 store writes no lanes.
    issue(1'b1, 2'd3, 32'h0000_100C, 32'hFFFF_FFFF);
    issue(1'b0, 2'd2, 32'h0000_100C, 32'd0);
    req = 1'b0;
    wait_idle();

    for (int k = 0; k < 200; k++) begin
      w_rand = 1'($urandom);
      force_err = ($urandom_range(0, 7) == 0);
      issue(w_rand, 2'($urandom_range(0, 2)), 32'h0000_1000 + 32'($urandom_range(0, 63)), $urandom);
      if ($urandom_range(0, 2) == 0) begin
        req = 1'b0;
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
    end
    req = 1'b0;
    force_err = 1'b0;
    wait_idle();

    // Reset while the bridge waits in RD_DATA.
    hold_r = 1'b1;
    issue(1'b0, 2'd2, 32'h0000_1010, 32'd0);
    req = 1'b0;
    n = 0;
    while (!bus.rready && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("reach_rd_data", {31'd0, bus.rready}, 32'd1);
    @(negedge clk);
    slave_off = 1'b1;
    inject_r = 1'b1;
    rst = 1'b1;
    #1;
    chk("rst_mid_valids", {27'd0, bus.arvalid, bus.rready, bus.awvalid, bus.wvalid, bus.bready}, 32'd0);
    chk("rst_mid_data_ok", {31'd0, data_ok}, 32'd0);
    sb_q.delete();
    hold_r = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    repeat (3) begin
      @(negedge clk);
      #1;
      if (data_ok) cnt++;
      chk("post_rst_rready", {31'd0, bus.rready}, 32'd0);
    end
    chk("post_rst_no_data_ok", cnt, 32'd0);
    inject_r = 1'b0;
    @(negedge clk);
    @(negedge clk);
    slave_off = 1'b0;
    @(negedge clk);
    issue(1'b0, 2'd2, 32'h0000_1010, 32'd0);
    req = 1'b0;
    wait_idle();

    $display("%0d/%0d checks passed", n_pass, n_check);
    $finish;
  end

endmodule
